bridge_arbiter: RTL and testbench
=================================

BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning DRAM word-address width on each requester port and on C_addr.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data width on each requester port and on C_data_w/C_data_r.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have, for each requester N in {0,1}, the following input ports: rqN_valid (1 bit, request strobe), rqN_r_wb (1 bit, 1=read, 0=write), rqN_addr (ADDR_W bits), rqN_data_w (DATA_W bits).
REQ-006 SHALL have, for each requester N in {0,1}, the following output ports: rqN_ready (1 bit, pending slot free), rqN_out_valid (1 bit, response pulse), rqN_data_r (DATA_W bits).
REQ-007 SHALL have the following output ports toward the bridge: C_in_valid (1 bit), C_r_wb (1 bit), C_addr (ADDR_W bits), C_data_w (DATA_W bits).
REQ-008 SHALL have the following input ports from the bridge: C_out_valid (1 bit), C_data_r (DATA_W bits).
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL accept a request from requester N on a cycle where rqN_valid && rqN_ready, latching r_wb/addr/data into a one-deep pending slot N; rqN_ready SHALL go low on the next cycle.
REQ-011 SHALL ignore rqN_valid while rqN_ready is low (no latch, no side effect).
REQ-012 SHALL set rqN_ready = !pendN combinationally.
REQ-013 SHALL implement FSM states IDLE, ISSUE and WAIT, with transitions IDLE->ISSUE when any pending slot is set, ISSUE->WAIT unconditionally, and WAIT->IDLE on C_out_valid; a slot accepted while in IDLE SHALL not be considered before the next cycle.
REQ-014 SHALL, in the IDLE->ISSUE transition, register the grant as follows: if only one slot is pending, grant it; if both are pending, grant the requester not equal to last_grant.
REQ-015 SHALL hold C_in_valid=1 for exactly the one ISSUE cycle, with C_r_wb/C_addr/C_data_w equal to the granted slot contents.
REQ-016 SHALL drive C_r_wb/C_addr/C_data_w to 0 in every cycle other than the ISSUE cycle.
REQ-017 SHALL, on C_out_valid in WAIT, on the next cycle: pulse rqG_out_valid high for one cycle with rqG_data_r equal to the captured C_data_r, clear pendG, and set last_grant=G.
REQ-018 SHALL return the captured C_data_r word as rqG_data_r for write responses as well as reads.
REQ-019 SHALL hold rqN_data_r at its last delivered value between pulses.
REQ-020 SHALL ignore C_out_valid in IDLE or ISSUE.
REQ-021 SHALL keep at most one transaction outstanding at the bridge.
REQ-022 SHALL allow a new request from requester G no earlier than the cycle its rqG_out_valid is high (ready already high then).
REQ-023 SHALL, if both requesters' valid and ready are high in the same cycle, accept both requests.
REQ-024 SHALL give a minimum per-transaction arbiter overhead of IDLE(1)+ISSUE(1)+response register(1) cycles plus the bridge latency.

Reset
REQ-025 SHALL, while rst is high, put the FSM in IDLE, clear pend0/pend1, and set last_grant=1 so that requester 0 wins the first tie.
REQ-026 SHALL, while rst is high, force C_in_valid, rq0_out_valid, rq1_out_valid and busy to 0, C_r_wb/C_addr/C_data_w to 0, rq0_data_r and rq1_data_r to 0, and rq0_ready=rq1_ready=1 (combinational from the cleared slots).
REQ-027 SHALL treat reset asserted mid-transaction as an abort: all state SHALL clear on that edge, no response pulse SHALL be issued for the aborted request, and any later C_out_valid SHALL be ignored per REQ-020.

Verification
REQ-028 SHALL verify a single read: rq0 read addr=0x12 -> exactly one C_in_valid with C_r_wb=1, C_addr=0x12; bridge returns 0xDEAD_BEEF_0000_0001 -> rq0_out_valid for 1 cycle with that data; rq0_ready high again.
REQ-029 SHALL verify a simultaneous tie: rq0 and rq1 valid on the same cycle after reset -> rq0 granted first, rq1 second; the second C_in_valid appears no earlier than 2 cycles after the first response.
REQ-030 SHALL verify fairness: both requesters re-request immediately upon each response for 8 rounds -> grants alternate 0,1,0,1,...; neither requester is served twice in a row while the other is pending.
REQ-031 SHALL verify a write: rq1 write addr=0xFF data=0x0123_4567_89AB_CDEF -> C_r_wb=0, C_addr=0xFF, C_data_w=0x0123_4567_89AB_CDEF for 1 cycle; rq1_out_valid is issued after C_out_valid.
REQ-032 SHALL verify a protocol violation: rq0_valid is pulsed while rq0_ready=0 with addr=0x55 -> it is dropped, and the in-flight request's address and data are unchanged.
REQ-033 SHALL verify reset in WAIT: rst asserted while waiting, then a late C_out_valid -> no rqN_out_valid; the FSM is in IDLE, both ready=1, and busy=0.

Source files
------------

// File: rtl/bridge_arbiter.sv
// bridge_arbiter: two-requester round-robin arbiter in front of a single-outstanding bridge port.
module bridge_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_valid,
  input  logic              rq0_r_wb,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_data_w,
  input  logic              rq1_valid,
  input  logic              rq1_r_wb,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_data_w,
  output logic              rq0_ready,
  output logic              rq0_out_valid,
  output logic [DATA_W-1:0] rq0_data_r,
  output logic              rq1_ready,
  output logic              rq1_out_valid,
  output logic [DATA_W-1:0] rq1_data_r,
  output logic              C_in_valid,
  output logic              C_r_wb,
  output logic [ADDR_W-1:0] C_addr,
  output logic [DATA_W-1:0] C_data_w,
  input  logic              C_out_valid,
  input  logic [DATA_W-1:0] C_data_r,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [1:0] pend_q, pend_d, rwb_q, rwb_d, ov_q, ov_d, v_in, rwb_in;
  logic [ADDR_W-1:0] addr_q [2], addr_d [2], addr_in [2];
  logic [DATA_W-1:0] wd_q [2], wd_d [2], wd_in [2], rd_q [2], rd_d [2];
  logic gnt_q, gnt_d, last_q, last_d, issue;
  assign v_in = {rq1_valid, rq0_valid};
  assign rwb_in = {rq1_r_wb, rq0_r_wb};
  assign addr_in[0] = rq0_addr;
  assign addr_in[1] = rq1_addr;
  assign wd_in[0] = rq0_data_w;
  assign wd_in[1] = rq1_data_w;
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    rwb_d = rwb_q;
    addr_d = addr_q;
    wd_d = wd_q;
    rd_d = rd_q;
    ov_d = '0;
    gnt_d = gnt_q;
    last_d = last_q;
    for (int n = 0; n < 2; n++)
      if (v_in[n] && !pend_q[n]) begin
        pend_d[n] = 1'b1;
        rwb_d[n] = rwb_in[n];
        addr_d[n] = addr_in[n];
        wd_d[n] = wd_in[n];
      end
    state_d = state_q == IDLE  ? (|pend_q ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT : (C_out_valid ? IDLE : WAIT);
    // on a tie, the requester that was not served last wins
    if (state_q == IDLE && |pend_q) gnt_d = &pend_q ? ~last_q : pend_q[1];
    if (state_q == WAIT && C_out_valid) begin
      ov_d[gnt_q] = 1'b1;
      rd_d[gnt_q] = C_data_r;
      pend_d[gnt_q] = 1'b0;
      last_d = gnt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      rwb_q <= '0;
      addr_q <= '{default: '0};
      wd_q <= '{default: '0};
      rd_q <= '{default: '0};
      ov_q <= '0;
      gnt_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      rwb_q <= rwb_d;
      addr_q <= addr_d;
      wd_q <= wd_d;
      rd_q <= rd_d;
      ov_q <= ov_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
    end
  end
  assign issue = state_q == ISSUE && !rst;
  assign C_in_valid = issue;
  assign C_r_wb = issue && rwb_q[gnt_q];
  assign C_addr = issue ? addr_q[gnt_q] : '0;
  assign C_data_w = issue ? wd_q[gnt_q] : '0;
  assign busy = !rst && state_q != IDLE;
  assign rq0_ready = !pend_q[0];
  assign rq1_ready = !pend_q[1];
  assign rq0_out_valid = ov_q[0] && !rst;
  assign rq1_out_valid = ov_q[1] && !rst;
  assign rq0_data_r = rd_q[0];
  assign rq1_data_r = rd_q[1];
endmodule

// File: tb/tb_bridge_arbiter.sv
// tb_bridge_arbiter: randomized bench with a transaction-level arbiter model and a latency-programmable bridge.
module tb_bridge_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] v = '0, rwb = '0;
  logic [7:0] addr [2] = '{default: '0};
  logic [63:0] wd [2] = '{default: '0};
  logic rq0_ready, rq0_out_valid, rq1_ready, rq1_out_valid;
  logic [63:0] rq0_data_r, rq1_data_r;
  logic C_in_valid, C_r_wb, busy;
  logic [7:0] C_addr;
  logic [63:0] C_data_w;
  logic C_out_valid = 1'b0;
  logic [63:0] C_data_r = '0;

  bridge_arbiter dut (
    .clk(clk), .rst(rst),
    .rq0_valid(v[0]), .rq0_r_wb(rwb[0]), .rq0_addr(addr[0]), .rq0_data_w(wd[0]),
    .rq1_valid(v[1]), .rq1_r_wb(rwb[1]), .rq1_addr(addr[1]), .rq1_data_w(wd[1]),
    .rq0_ready(rq0_ready), .rq0_out_valid(rq0_out_valid), .rq0_data_r(rq0_data_r),
    .rq1_ready(rq1_ready), .rq1_out_valid(rq1_out_valid), .rq1_data_r(rq1_data_r),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
    .C_out_valid(C_out_valid), .C_data_r(C_data_r), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc_n = 0, m_acc = 0, n_resp = 0, br_cnt = 0, br_lat = 1;
  bit br_auto = 1, br_rnd = 0, br_fix_en = 0;
  logic [63:0] br_fix = '0, br_data = '0;
  // model: pending slots, last winner, outstanding flag and delivered data per requester
  logic [1:0] m_pend = '0, m_rwb = '0;
  logic m_last = 1'b1, m_wait = 1'b0, m_g = 1'b0;
  logic [7:0] m_addr [2];
  logic [63:0] m_wd [2], m_dr [2];
  int g_log [$], in_cyc [$], out_cyc [$];
  logic [72:0] c_log [$];
  logic [64:0] o_log [$];

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic cyc();
    logic [1:0] acc, prev, ovs, rdys;
    logic resp, rst_e, g;
    logic [63:0] rdat, drs [2];
    rst_e = rst;
    for (int n = 0; n < 2; n++) acc[n] = v[n] && !m_pend[n] && !rst;
    resp = C_out_valid && m_wait && !rst;
    rdat = C_data_r;
    @(negedge clk);
    cyc_n++;
    prev = m_pend;
    if (rst_e) begin
      m_pend = '0; m_last = 1'b1; m_wait = 1'b0; m_dr[0] = '0; m_dr[1] = '0; br_cnt = 0;
    end
    for (int n = 0; n < 2; n++)
      if (acc[n]) begin
        m_pend[n] = 1'b1; m_rwb[n] = rwb[n]; m_addr[n] = addr[n]; m_wd[n] = wd[n]; m_acc++;
      end
    if (resp) begin
      m_pend[m_g] = 1'b0; m_last = m_g; m_wait = 1'b0; m_dr[m_g] = rdat; n_resp++;
    end
    ovs = {rq1_out_valid, rq0_out_valid};
    rdys = {rq1_ready, rq0_ready};
    drs[0] = rq0_data_r;
    drs[1] = rq1_data_r;
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (ovs[n] !== (resp && m_g == 1'(n))) begin
        failures++; $display("FAIL out_valid%0d cyc=%0d got=%b exp=%b", n, cyc_n, ovs[n], resp && m_g == 1'(n));
      end
      checks++;
      if (drs[n] !== m_dr[n]) begin
        failures++; $display("FAIL data_r%0d cyc=%0d got=%h exp=%h", n, cyc_n, drs[n], m_dr[n]);
      end
      checks++;
      if (rdys[n] !== !m_pend[n]) begin
        failures++; $display("FAIL ready%0d cyc=%0d got=%b exp=%b", n, cyc_n, rdys[n], !m_pend[n]);
      end
      if (ovs[n] === 1'b1) o_log.push_back({1'(n), drs[n]});
    end
    if (br_cnt > 0) begin
      br_cnt--;
      if (br_cnt == 0) begin C_out_valid = 1'b1; C_data_r = br_data; out_cyc.push_back(cyc_n); end
    end else begin
      C_out_valid = 1'b0; C_data_r = r64();
    end
    if (C_in_valid === 1'b1) begin
      g = (prev == 2'b11) ? !m_last : prev[1];
      checks++;
      if (m_wait || prev == 2'b00 || rst_e) begin
        failures++; $display("FAIL issue_legal cyc=%0d got=issue exp=no_issue", cyc_n);
      end
      checks++;
      if ({C_r_wb, C_addr, C_data_w} !== {m_rwb[g], m_addr[g], m_wd[g]}) begin
        failures++;
        $display("FAIL issue_fields cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc_n, C_r_wb, C_addr, C_data_w, m_rwb[g], m_addr[g], m_wd[g]);
      end
      m_wait = 1'b1; m_g = g;
      g_log.push_back(int'(g)); in_cyc.push_back(cyc_n); c_log.push_back({C_r_wb, C_addr, C_data_w});
      if (br_auto) begin
        br_cnt = br_rnd ? int'($urandom_range(1, 4)) : br_lat;
        br_data = br_fix_en ? br_fix : r64();
      end
    end else begin
      checks++;
      if ({C_r_wb, C_addr, C_data_w} !== 73'b0) begin
        failures++; $display("FAIL idle_fields cyc=%0d got=%b/%h/%h exp=0", cyc_n, C_r_wb, C_addr, C_data_w);
      end
    end
    checks++;
    if (busy !== m_wait) begin
      failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc_n, busy, m_wait);
    end
  endtask

  task automatic drain(input int budget);
    bit done = 0;
    for (int t = 0; t < budget && !done; t++) begin
      done = m_pend == 2'b00 && !m_wait && br_cnt == 0;
      if (!done) cyc();
    end
    checks++;
    if (!done) begin
      failures++; $display("FAIL drain_timeout got=pend%b_wait%b exp=idle", m_pend, m_wait);
    end
  endtask

  task automatic do_reset();
    v = '0; rst = 1'b1; cyc(); cyc(); rst = 1'b0; cyc();
  endtask

  task automatic req(input int n, input logic r, input logic [7:0] a, input logic [63:0] d);
    v[n] = 1'b1; rwb[n] = r; addr[n] = a; wd[n] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc();
    checks++;
    if ({rq1_ready, rq0_ready, busy, C_in_valid, rq1_out_valid, rq0_out_valid} !== 6'b110000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=110000", {rq1_ready, rq0_ready, busy, C_in_valid, rq1_out_valid, rq0_out_valid});
    end
    checks++;
    if ({rq0_data_r, rq1_data_r} !== 128'b0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0", rq0_data_r, rq1_data_r);
    end
    rst = 1'b0; cyc();
  endtask

  task automatic test_single_read();
    int ib = c_log.size(), ob = o_log.size();
    br_fix_en = 1; br_fix = 64'hDEAD_BEEF_0000_0001; br_lat = 2;
    req(0, 1'b1, 8'h12, r64()); cyc(); v = '0;
    drain(30);
    br_fix_en = 0;
    checks++;
    if (c_log.size() != ib + 1 || c_log[ib][72:64] !== 9'h112) begin
      failures++; $display("FAIL read_issue got=n%0d exp=one_read_at_12", c_log.size() - ib);
    end
    checks++;
    if (o_log.size() != ob + 1 || o_log[ob] !== {1'b0, 64'hDEAD_BEEF_0000_0001}) begin
      failures++; $display("FAIL read_resp got=n%0d exp=rq0_deadbeef00000001", o_log.size() - ob);
    end
    checks++;
    if (rq0_ready !== 1'b1) begin
      failures++; $display("FAIL read_ready got=%b exp=1", rq0_ready);
    end
  endtask

  task automatic test_tie();
    int gb, ib, ob;
    do_reset();
    gb = g_log.size(); ib = in_cyc.size(); ob = out_cyc.size(); br_lat = 1;
    req(0, 1'b1, 8'h21, r64()); req(1, 1'b1, 8'h31, r64()); cyc(); v = '0;
    drain(40);
    checks++;
    if (g_log.size() != gb + 2 || g_log[gb] != 0 || g_log[gb + 1] != 1) begin
      failures++; $display("FAIL tie_order got=n%0d exp=0_then_1", g_log.size() - gb);
    end
    checks++;
    if (in_cyc.size() < ib + 2 || out_cyc.size() <= ob || in_cyc[ib + 1] - out_cyc[ob] < 2) begin
      failures++; $display("FAIL tie_gap got=too_soon exp=at_least_2");
    end
  endtask

  task automatic test_fairness();
    int gb, reqs;
    do_reset();
    gb = g_log.size(); br_rnd = 1;
    req(0, 1'(($urandom())), 8'($urandom()), r64()); req(1, 1'($urandom()), 8'($urandom()), r64());
    reqs = 2; cyc(); v = '0;
    for (int t = 0; t < 400 && (reqs < 16 || m_wait || m_pend != 0); t++) begin
      cyc();
      v = '0;
      if (rq0_out_valid === 1'b1 && reqs < 16) begin req(0, 1'($urandom()), 8'($urandom()), r64()); reqs++; end
      if (rq1_out_valid === 1'b1 && reqs < 16) begin req(1, 1'($urandom()), 8'($urandom()), r64()); reqs++; end
    end
    cyc(); v = '0;
    drain(40);
    br_rnd = 0;
    checks++;
    if (g_log.size() - gb != 16) begin
      failures++; $display("FAIL fair_count got=%0d exp=16", g_log.size() - gb);
    end
    for (int i = 0; i < 16 && gb + i < g_log.size(); i++) begin
      checks++;
      if (g_log[gb + i] != i % 2) begin
        failures++; $display("FAIL fair_grant%0d got=%0d exp=%0d", i, g_log[gb + i], i % 2);
      end
    end
  endtask

  task automatic test_write();
    int ib = c_log.size(), ob = o_log.size();
    br_lat = 3;
    req(1, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF); cyc(); v = '0;
    drain(30);
    checks++;
    if (c_log.size() != ib + 1 || c_log[ib] !== {1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF}) begin
      failures++; $display("FAIL write_issue got=n%0d exp=write_ff_0123456789abcdef", c_log.size() - ib);
    end
    checks++;
    if (o_log.size() != ob + 1 || o_log[ob][64] !== 1'b1) begin
      failures++; $display("FAIL write_resp got=n%0d exp=one_rq1_pulse", o_log.size() - ob);
    end
  endtask

  task automatic test_violation();
    int ib = c_log.size();
    logic [63:0] d = r64();
    br_lat = 3;
    req(0, 1'b1, 8'h11, d); cyc(); v = '0; cyc();
    req(0, 1'b0, 8'h55, r64()); cyc(); v = '0;
    drain(30);
    checks++;
    if (c_log.size() != ib + 1 || c_log[ib] !== {1'b1, 8'h11, d}) begin
      failures++; $display("FAIL viol_issue got=n%0d exp=single_read_11", c_log.size() - ib);
    end
  endtask

  task automatic test_reset_wait();
    int ob;
    do_reset();
    br_auto = 0;
    req(1, 1'b1, 8'h77, r64()); cyc(); v = '0;
    for (int t = 0; t < 10 && !m_wait; t++) cyc();
    checks++;
    if (!m_wait) begin
      failures++; $display("FAIL rw_issue got=no_issue exp=issue");
    end
    cyc(); cyc();
    ob = o_log.size();
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    C_out_valid = 1'b1; C_data_r = r64(); cyc(); cyc(); cyc();
    br_auto = 1;
    checks++;
    if (o_log.size() != ob) begin
      failures++; $display("FAIL rw_pulse got=%0d exp=0", o_log.size() - ob);
    end
    checks++;
    if ({busy, rq1_ready, rq0_ready} !== 3'b011) begin
      failures++; $display("FAIL rw_state got=%b exp=011", {busy, rq1_ready, rq0_ready});
    end
  endtask

  task automatic test_random();
    int a0 = m_acc, r0 = n_resp;
    br_rnd = 1;
    for (int t = 0; t < 300; t++) begin
      for (int n = 0; n < 2; n++) begin
        v[n] = $urandom_range(0, 2) == 0; rwb[n] = 1'($urandom()); addr[n] = 8'($urandom()); wd[n] = r64();
      end
      cyc();
    end
    v = '0;
    drain(60);
    br_rnd = 0;
    checks++;
    if (m_acc - a0 != n_resp - r0 || n_resp == r0) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", n_resp - r0, m_acc - a0);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_fairness();
    test_write();
    test_violation();
    test_reset_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
